// File: rtl/led_indicator_bank.sv
// led_indicator_bank: multi-channel LED driver with a shared tick prescaler and off/on/blink/stretch modes
module led_indicator_bank #(
    parameter int FREQ       = 120000000,
    parameter int TICK_HZ    = 1000,
    parameter int CH         = 4,
    parameter int STRETCH_MS = 50,
    parameter bit LED_POL    = 1'b1
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [2*CH-1:0]   iMODE,
    input  logic [16*CH-1:0]  iHALF_MS,
    input  logic [CH-1:0]     iEVENT,
    output logic [CH-1:0]     oLED
);
    localparam int          DIV     = FREQ / TICK_HZ;
    localparam logic [31:0] LAST    = 32'(DIV - 1);
    localparam logic [15:0] STRETCH = 16'(STRETCH_MS);

    logic [31:0]   preCnt;
    logic          tick;
    logic [1:0]    modeQ   [CH];
    logic [15:0]   bcnt    [CH];
    logic [15:0]   scnt    [CH];
    logic [15:0]   lastCnt [CH];
    logic [CH-1:0] blit;
    logic [CH-1:0] lit;

    assign tick = preCnt == LAST;
    assign oLED = LED_POL ? lit : ~lit;

    for (genvar g = 0; g < CH; g++) begin : gHalf
        assign lastCnt[g] = (iHALF_MS[16*g +: 16] == 16'd0) ? 16'd0 : iHALF_MS[16*g +: 16] - 16'd1;
    end

    // free-running prescaler shared by every channel, never resynchronised
    always_ff @(posedge iCLK or negedge iRST_n)
        if (!iRST_n)
            preCnt <= '0;
        else
            preCnt <= tick ? '0 : preCnt + 32'd1;

    // per-channel state; a mode change preempts tick and event, lit is held on that edge
    always_ff @(posedge iCLK or negedge iRST_n)
        if (!iRST_n) begin
            for (int i = 0; i < CH; i++) begin
                modeQ[i] <= 2'b00;
                bcnt[i]  <= '0;
                scnt[i]  <= '0;
            end
            blit <= '1;
            lit  <= '1;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (iMODE[2*i +: 2] != modeQ[i]) begin
                    modeQ[i] <= iMODE[2*i +: 2];
                    bcnt[i]  <= '0;
                    blit[i]  <= 1'b1;
                    scnt[i]  <= '0;
                end else begin
                    case (modeQ[i])
                        2'b00: lit[i] <= 1'b0;
                        2'b01: lit[i] <= 1'b1;
                        2'b10: begin
                            if (tick) begin
                                if (bcnt[i] >= lastCnt[i]) begin
                                    bcnt[i] <= '0;
                                    blit[i] <= ~blit[i];
                                end else begin
                                    bcnt[i] <= bcnt[i] + 16'd1;
                                end
                            end
                            lit[i] <= blit[i];
                        end
                        default: begin
                            if (iEVENT[i])
                                scnt[i] <= STRETCH;
                            else if (tick && scnt[i] != 16'd0)
                                scnt[i] <= scnt[i] - 16'd1;
                            lit[i] <= iEVENT[i] | (scnt[i] != 16'd0);
                        end
                    endcase
                end
            end
        end
endmodule
